// File: rtl/cdc_reg_responder.sv
// Byte-serial register responder: 'W' addr data -> ACK/NAK, 'R' addr -> value/NAK.
// Inter-byte timeout abandons a partial command; NAKs and timeouts are counted.
module cdc_reg_responder #(
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int NUM_REGS       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] out_data_i,
    input  logic       out_valid_i,
    output logic       out_ready_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    output logic [7:0] gpio_o,
    output logic [7:0] err_cnt_o
);

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] REG_LIM = 9'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    resp_q, resp_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    err_q;
    logic          err_inc;
    logic          wr_en;
    logic          accept;
    logic          byte_hit;
    logic          addr_hit;
    logic          tmo_hit;
    logic [7:0]    rd_byte;
    logic [7:0]    regs_q [NUM_REGS];

    assign accept   = out_valid_i && out_ready_o;
    assign byte_hit = {1'b0, out_data_i} < REG_LIM;
    assign addr_hit = {1'b0, addr_q} < REG_LIM;
    assign tmo_hit  = tmo_q == TMO_LAST;
    assign rd_byte  = regs_q[out_data_i[AW-1:0]];

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        resp_d  = resp_q;
        tmo_d   = tmo_q;
        err_inc = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (accept) begin
                    unique case (1'b1)
                        out_data_i == OP_W: begin
                            is_wr_d = 1'b1;
                            state_d = GET_ADDR;
                        end
                        out_data_i == OP_R: begin
                            is_wr_d = 1'b0;
                            state_d = GET_ADDR;
                        end
                        default: begin
                            resp_d  = NAK;
                            err_inc = 1'b1;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            GET_ADDR: begin
                if (accept) begin
                    addr_d = out_data_i;
                    tmo_d  = '0;
                    if (is_wr_q) begin
                        state_d = GET_DATA;
                    end else begin
                        resp_d  = byte_hit ? rd_byte : NAK;
                        err_inc = !byte_hit;
                        state_d = RESP;
                    end
                end else if (tmo_hit) begin
                    tmo_d   = '0;
                    err_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            GET_DATA: begin
                if (accept) begin
                    tmo_d   = '0;
                    wr_en   = addr_hit;
                    resp_d  = addr_hit ? ACK : NAK;
                    err_inc = !addr_hit;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    tmo_d   = '0;
                    err_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                if (in_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            resp_q  <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
            tmo_q   <= tmo_d;
            if (err_inc && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    // Register file; addresses past NUM_REGS never raise wr_en.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst_i) begin
                regs_q[i] <= '0;
            end else if (wr_en && addr_q[AW-1:0] == AW'(i)) begin
                regs_q[i] <= out_data_i;
            end
        end
    end

    assign out_ready_o = state_q != RESP;
    assign in_valid_o  = state_q == RESP;
    assign in_data_o   = resp_q;
    assign gpio_o      = regs_q[0];
    assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_cdc_reg_responder.sv
// Bench for cdc_reg_responder: directed scenarios plus random traffic,
// all checked every cycle against a command-level reference model.
module tb_cdc_reg_responder;

    localparam int T = 40;
    localparam int N = 16;

    logic       clk;
    logic       rst;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] gpio;
    logic [7:0] err_cnt;

    int vectors = 0;
    int misc    = 0;

    cdc_reg_responder #(
        .TIMEOUT_CYCLES(T),
        .NUM_REGS(N)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .out_data_i(out_data),
        .out_valid_i(out_valid),
        .out_ready_o(out_ready),
        .in_data_o(in_data),
        .in_valid_o(in_valid),
        .in_ready_i(in_ready),
        .gpio_o(gpio),
        .err_cnt_o(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: collected command bytes, idle gap, pending response.
    logic [7:0] m_cmd [$];
    logic [7:0] m_regs [N];
    int         m_idle;
    int         m_resp;
    int         m_err;
    bit         m_init = 1'b0;

    function automatic void m_nak();
        m_resp = 8'h15;
        if (m_err < 255) m_err++;
        m_cmd.delete();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1'b1;
            m_cmd.delete();
            m_idle = 0;
            m_resp = -1;
            m_err  = 0;
            for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
        end else if (m_init) begin
            if (m_resp >= 0) begin
                if (in_ready) m_resp = -1;
            end else if (out_valid) begin
                m_cmd.push_back(out_data);
                m_idle = 0;
                if (m_cmd[0] != 8'h57 && m_cmd[0] != 8'h52) begin
                    m_nak();
                end else if (m_cmd.size() == 2 && m_cmd[0] == 8'h52) begin
                    if (m_cmd[1] < N) begin
                        m_resp = int'(m_regs[m_cmd[1]]);
                        m_cmd.delete();
                    end else begin
                        m_nak();
                    end
                end else if (m_cmd.size() == 3) begin
                    if (m_cmd[1] < N) begin
                        m_regs[m_cmd[1]] = m_cmd[2];
                        m_resp = 8'h06;
                        m_cmd.delete();
                    end else begin
                        m_nak();
                    end
                end
            end else if (m_cmd.size() > 0) begin
                m_idle++;
                if (m_idle == T) begin
                    m_cmd.delete();
                    m_idle = 0;
                    if (m_err < 255) m_err++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            logic ev;
            logic [7:0] ed;
            ev = m_resp >= 0;
            ed = 8'(m_resp);
            vectors++;
            if (out_ready !== !ev || in_valid !== ev || gpio !== m_regs[0] ||
                err_cnt !== 8'(m_err) || (ev && in_data !== ed)) begin
                misc++;
                $display("FAIL model t=%0t: rdy=%b vld=%b data=%h gpio=%h err=%h required rdy=%b vld=%b data=%h gpio=%h err=%h",
                         $time, out_ready, in_valid, in_data, gpio, err_cnt,
                         !ev, ev, ed, m_regs[0], 8'(m_err));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        out_valid = 1'b1;
        out_data  = b;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = out_ready;
            tick();
        end
        out_valid = 1'b0;
        if (!acc) begin
            vectors++;
            misc++;
            $display("FAIL send_stall: byte %h never accepted", b);
        end
    endtask

    // Response must be present one cycle after the final byte.
    task automatic expect_resp(input string name, input logic [7:0] v);
        chk({name, "_valid"}, 32'(in_valid), 32'd1);
        chk(name, 32'(in_data), 32'(v));
        if (in_ready) tick();
    endtask

    initial begin
        rst = 1'b1;
        out_valid = 1'b0;
        out_data = 8'h00;
        in_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(in_valid), 32'd0);
        chk("rst_data", 32'(in_data), 32'd0);
        chk("rst_gpio", 32'(gpio), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(out_ready), 32'd1);

        send(8'h57); send(8'h00); send(8'hA5);
        expect_resp("w0_ack", 8'h06);
        chk("w0_gpio", 32'(gpio), 32'hA5);
        chk("w0_err", 32'(err_cnt), 32'd0);

        send(8'h57); send(8'h03); send(8'h3C);
        expect_resp("w3_ack", 8'h06);
        send(8'h52); send(8'h03);
        expect_resp("r3", 8'h3C);

        in_ready = 1'b0;
        send(8'h52); send(8'h03);
        for (int i = 0; i < 10; i++) begin
            chk("stall_state", {29'd0, in_valid, out_ready, 1'b0} | 32'(in_data) << 8,
                32'h3C04);
            tick();
        end
        in_ready = 1'b1;
        chk("stall_release", 32'(in_data), 32'h3C);
        tick();
        chk("post_xfer_valid", 32'(in_valid), 32'd0);
        chk("post_xfer_ready", 32'(out_ready), 32'd1);

        send(8'h41);
        expect_resp("bad_op", 8'h15);
        send(8'h52); send(8'h10);
        expect_resp("bad_addr", 8'h15);
        chk("nak_err", 32'(err_cnt), 32'd2);

        send(8'h57); send(8'h01);
        repeat (T) tick();
        chk("tmo_valid", 32'(in_valid), 32'd0);
        chk("tmo_err", 32'(err_cnt), 32'd3);
        send(8'h52); send(8'h01);
        expect_resp("tmo_r1", 8'h00);

        send(8'h57); send(8'h05);
        repeat (T - 1) tick();
        send(8'h77);
        expect_resp("edge_ack", 8'h06);
        send(8'h52); send(8'h05);
        expect_resp("edge_r5", 8'h77);
        chk("edge_err", 32'(err_cnt), 32'd3);

        send(8'h57); send(8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(in_valid), 32'd0);
        chk("mid_rst_gpio", 32'(gpio), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        send(8'h52); send(8'h03);
        expect_resp("mid_rst_r3", 8'h00);
        for (int i = 0; i < 300; i++) begin
            send(8'h41);
            tick();
        end
        chk("sat_err", 32'(err_cnt), 32'hFF);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        begin
            int quiet;
            quiet = 0;
            for (int c = 0; c < 6000; c++) begin
                rst = ($urandom_range(0, 799) == 0);
                if (quiet == 0 && $urandom_range(0, 99) == 0) quiet = T + 3;
                if (quiet > 0) begin
                    quiet--;
                    out_valid = 1'b0;
                end else begin
                    out_valid = $urandom_range(0, 3) != 0;
                end
                case ($urandom_range(0, 5))
                    0: out_data = 8'h57;
                    1: out_data = 8'h52;
                    2, 3: out_data = 8'($urandom_range(0, 17));
                    default: out_data = 8'($urandom);
                endcase
                in_ready = $urandom_range(0, 2) != 0;
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
